// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART controller: memory op codes, default
// baud divider, FSM state encodings and op-code classification helpers.
package uart_ctrl_pkg;

    // Default divider: 50 MHz system clock, 115200 baud.
    localparam int unsigned UART_CLKS_PER_BIT = 434;

    // Memory-stage op codes.
    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LBU = 4'd2;
    localparam logic [3:0] MEM_LH  = 4'd3;
    localparam logic [3:0] MEM_LHU = 4'd4;
    localparam logic [3:0] MEM_LW  = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // True for any op code that reads the UART data register.
    function automatic logic is_load(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: is_load = 1'b1;
            default:                                  is_load = 1'b0;
        endcase
    endfunction

    // True for any op code that writes the UART data register.
    function automatic logic is_store(input logic [3:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
            default:                is_store = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and the
// received-byte holding register with its pending flag.
module uart_rx
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    input  logic       clear_i,
    output logic [7:0] rx_byte_o,
    output logic       data_ready_o
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    logic        sync1_q, sync2_q, prev_q;
    rx_state_t   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        ready_q, ready_d;

    // Synchronize the asynchronous line and keep one delayed copy for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver state, counters and byte holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic; a completing byte overrides a same-cycle clear.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        ready_d = ready_q & ~clear_i;
        case (state_q)
            RX_IDLE: begin
                baud_d = 16'd0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d = 16'd0;
                    bit_d  = 3'd0;
                    if (sync2_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = 16'd0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = 16'd0;
                    state_d = RX_IDLE;
                    if (sync2_q) begin
                        byte_d  = shift_q;
                        ready_d = 1'b1;
                    end else begin
                        byte_d  = byte_q;
                    end
                end else begin
                    state_d = RX_STOP;
                end
            end
            default: begin
                state_d = RX_IDLE;
                baud_d  = 16'd0;
                bit_d   = 3'd0;
            end
        endcase
    end

    assign rx_byte_o    = byte_q;
    assign data_ready_o = ready_q;

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART: decodes load/store strobes, runs the transmit FSM and
// hosts the receiver sub-module.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_req,
    input  logic [3:0]  uart_op,
    input  logic [31:0] uart_wdata,
    output logic [31:0] uart_rdata,
    output logic        data_ready,
    output logic        tx_ready,
    input  logic        rxd,
    output logic        txd
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic        load_s, store_s;
    logic [7:0]  rx_byte_s;
    logic        unused_wdata_s;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  data_q, data_d;
    logic        txd_q, txd_d;

    assign load_s         = uart_req & is_load(uart_op);
    assign store_s        = uart_req & is_store(uart_op);
    assign unused_wdata_s = ^uart_wdata[31:8];

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rxd_i        (rxd),
        .clear_i      (load_s),
        .rx_byte_o    (rx_byte_s),
        .data_ready_o (data_ready)
    );

    // Transmit state, counters, latched byte and registered line output.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            baud_q     <= 16'd0;
            bit_q      <= 3'd0;
            data_q     <= 8'h00;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            txd_q      <= txd_d;
        end
    end

    // Transmit next-state logic; stores arriving while busy fall through unused.
    always_comb begin
        tx_state_d = tx_state_q;
        baud_d     = baud_q + 16'd1;
        bit_d      = bit_q;
        data_d     = data_q;
        case (tx_state_q)
            TX_IDLE: begin
                baud_d = 16'd0;
                bit_d  = 3'd0;
                if (store_s) begin
                    tx_state_d = TX_START;
                    data_d     = uart_wdata[7:0];
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (baud_q == BAUD_LAST) begin
                    tx_state_d = TX_DATA;
                    baud_d     = 16'd0;
                    bit_d      = 3'd0;
                end else begin
                    tx_state_d = TX_START;
                end
            end
            TX_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = 16'd0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_state_d = TX_DATA;
                    end
                end else begin
                    tx_state_d = TX_DATA;
                end
            end
            TX_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    tx_state_d = TX_IDLE;
                    baud_d     = 16'd0;
                end else begin
                    tx_state_d = TX_STOP;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                baud_d     = 16'd0;
                bit_d      = 3'd0;
            end
        endcase
    end

    // Line level is derived from the upcoming state so txd changes with the state.
    always_comb begin
        case (tx_state_d)
            TX_IDLE:  txd_d = 1'b1;
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = data_d[bit_d];
            TX_STOP:  txd_d = 1'b1;
            default:  txd_d = 1'b1;
        endcase
    end

    assign txd        = txd_q;
    assign tx_ready   = (tx_state_q == TX_IDLE);
    assign uart_rdata = {24'h000000, rx_byte_s};

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl with CLKS_PER_BIT=4. Expected TX and RX
// bytes are queued by the stimulus; two monitor processes pop and compare.
module tb_uart_ctrl;
    import uart_ctrl_pkg::*;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_req = 1'b0;
    logic [3:0]  uart_op = MEM_NOP;
    logic [31:0] uart_wdata = 32'h0;
    logic [31:0] uart_rdata;
    logic        data_ready;
    logic        tx_ready;
    logic        rxd = 1'b1;
    logic        txd;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    uart_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_req   (uart_req),
        .uart_op    (uart_op),
        .uart_wdata (uart_wdata),
        .uart_rdata (uart_rdata),
        .data_ready (data_ready),
        .tx_ready   (tx_ready),
        .rxd        (rxd),
        .txd        (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [3:0] op, input logic [31:0] data);
        uart_req   = 1'b1;
        uart_op    = op;
        uart_wdata = data;
        tick();
        uart_req   = 1'b0;
        uart_op    = MEM_NOP;
    endtask

    task automatic load(input logic [3:0] op);
        uart_req = 1'b1;
        uart_op  = op;
        tick();
        uart_req = 1'b0;
        uart_op  = MEM_NOP;
    endtask

    // Drives start, 8 data bits LSB first and stop; returns 40 ticks later.
    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) tick();
        end
        rxd = stop_bit;
        repeat (CPB) tick();
        rxd = 1'b1;
    endtask

    // TX monitor: on each tx_ready fall, checks 40 txd cycles then tx_ready high.
    initial begin : tx_mon
        logic       prev_rdy;
        logic       aborted;
        logic [7:0] b;
        logic       exp_bit;
        int         idx;
        prev_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_ready === 1'b0 && prev_rdy === 1'b1 && rst === 1'b0) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected_frame", 32'd1, 32'd0);
                    b = 8'h00;
                end else begin
                    b = tx_q.pop_front();
                end
                aborted = 1'b0;
                for (int c = 0; c < 10 * CPB; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    idx = c / CPB;
                    if (idx == 0) exp_bit = 1'b0;
                    else if (idx == 9) exp_bit = 1'b1;
                    else exp_bit = b[idx - 1];
                    check("tx_txd_bit", {31'd0, txd}, {31'd0, exp_bit});
                    check("tx_ready_busy", {31'd0, tx_ready}, 32'd0);
                end
                if (!aborted) begin
                    @(negedge clk);
                    check("tx_ready_after_frame", {31'd0, tx_ready}, 32'd1);
                end
            end
            prev_rdy = tx_ready;
        end
    end

    // RX monitor: a new byte shows as data_ready rising or rdata changing while pending.
    initial begin : rx_mon
        logic        prev_dr;
        logic [31:0] prev_rd;
        logic [7:0]  b;
        prev_dr = 1'b0;
        prev_rd = 32'h0;
        forever begin
            @(negedge clk);
            if (data_ready === 1'b1 && (prev_dr !== 1'b1 || uart_rdata !== prev_rd)) begin
                if (rx_q.size() == 0) begin
                    check("rx_unexpected_byte", uart_rdata, 32'hFFFFFFFF);
                end else begin
                    b = rx_q.pop_front();
                    check("rx_byte", uart_rdata, {24'h0, b});
                end
            end
            prev_dr = data_ready;
            prev_rd = uart_rdata;
        end
    end

    initial begin : stim
        // Reset and idle state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_data_ready", {31'd0, data_ready}, 32'd0);
        check("reset_rdata", uart_rdata, 32'h0);
        tick();

        // SW 0xA5, then a second store 10 cycles into the frame is dropped
        tx_q.push_back(8'hA5);
        store(MEM_SW, 32'h000000A5);
        repeat (9) tick();
        store(MEM_SW, 32'h0000003C);
        repeat (30) tick();
        check("tx_ready_back", {31'd0, tx_ready}, 32'd1);
        repeat (10) tick();
        check("txd_idle_after_drop", {31'd0, txd}, 32'd1);
        check("tx_ready_after_drop", {31'd0, tx_ready}, 32'd1);

        // NOP request is ignored; SB uses only the low byte
        store(MEM_NOP, 32'h00000055);
        check("nop_ignored", {31'd0, tx_ready}, 32'd1);
        tx_q.push_back(8'hC3);
        store(MEM_SB, 32'h123456C3);
        check("sb_accepted", {31'd0, tx_ready}, 32'd0);
        repeat (45) tick();

        // RX 0x5A: 2 sync flops + edge detect put completion 41 edges after the start drive
        rx_q.push_back(8'h5A);
        rx_frame(8'h5A, 1'b1);
        check("rx_5a_not_yet", {31'd0, data_ready}, 32'd0);
        tick();
        check("rx_5a_ready", {31'd0, data_ready}, 32'd1);
        check("rx_5a_rdata", uart_rdata, 32'h0000005A);
        repeat (3) tick();
        load(MEM_NOP);
        check("nop_keeps_ready", {31'd0, data_ready}, 32'd1);
        uart_req = 1'b1;
        uart_op  = MEM_LBU;
        #1;
        check("rdata_same_cycle", uart_rdata, 32'h0000005A);
        tick();
        uart_req = 1'b0;
        uart_op  = MEM_NOP;
        check("load_clears_ready", {31'd0, data_ready}, 32'd0);

        // One-cycle glitch produces nothing
        repeat (4) tick();
        rxd = 1'b0;
        tick();
        rxd = 1'b1;
        repeat (20) tick();
        check("glitch_no_byte", {31'd0, data_ready}, 32'd0);

        // Framing error: 0x77 with a low stop bit is discarded
        rx_frame(8'h77, 1'b0);
        repeat (6) tick();
        check("framing_no_ready", {31'd0, data_ready}, 32'd0);
        check("framing_rdata_kept", uart_rdata, 32'h0000005A);
        repeat (4) tick();

        // Overrun: 0x11 then 0x22, load coinciding with 0x22 completion
        rx_q.push_back(8'h11);
        rx_frame(8'h11, 1'b1);
        tick();
        check("rx_11_ready", {31'd0, data_ready}, 32'd1);
        tick();
        rx_q.push_back(8'h22);
        fork
            rx_frame(8'h22, 1'b1);
            begin
                repeat (40) tick();
                load(MEM_LW);
            end
        join
        check("overrun_ready_kept", {31'd0, data_ready}, 32'd1);
        check("overrun_rdata", uart_rdata, 32'h00000022);
        load(MEM_LH);
        check("overrun_then_clear", {31'd0, data_ready}, 32'd0);
        repeat (4) tick();

        // Reset 15 cycles into a TX frame while an RX frame is in flight
        fork
            rx_frame(8'hFF, 1'b1);
            begin
                tx_q.push_back(8'h81);
                store(MEM_SW, 32'h00000081);
                repeat (14) tick();
                rst = 1'b1;
                tick();
                check("rst_mid_txd", {31'd0, txd}, 32'd1);
                check("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
                rst = 1'b0;
            end
        join
        repeat (10) tick();
        check("rst_mid_rx_no_byte", {31'd0, data_ready}, 32'd0);
        check("rst_mid_rdata", uart_rdata, 32'h0);
        check("rst_idle_txd", {31'd0, txd}, 32'd1);

        // Every queued expectation must have been consumed
        check("tx_queue_empty", tx_q.size(), 32'd0);
        check("rx_queue_empty", rx_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
